elec_layer_os_tx: RTL and testbench

ELEC_LAYER_OS_TX -- requirements
Module: elec_layer_os_tx

---
 rtl/elec_layer_pkg.sv | 24 ++
 rtl/elec_prbs11_gen.sv | 37 +++
 rtl/elec_layer_os_tx.sv | 155 +++++++++++++++
 tb/tb_elec_layer_os_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/elec_layer_pkg.sv
// rtl/elec_layer_pkg.sv - shared encodings and constants for the electrical-layer ordered-set transmitter
package elec_layer_pkg;

    typedef enum logic [2:0] {
        CMD_IDLE  = 3'd0,
        CMD_SLOS1 = 3'd1,
        CMD_SLOS2 = 3'd2,
        CMD_TS1   = 3'd3,
        CMD_TS2   = 3'd4,
        CMD_DATA  = 3'd5
    } os_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SLOS,
        ST_TS,
        ST_DATA
    } os_state_e;

    localparam logic [31:0] TS1_PATTERN = 32'h0F0F_00F2;
    localparam logic [31:0] TS2_PATTERN = 32'h0F0F_00F4;
    localparam logic [10:0] PRBS11_SEED = 11'h7FF;

endpackage

// File: rtl/elec_prbs11_gen.sv
// rtl/elec_prbs11_gen.sv - PRBS11 (x^11+x^9+1) source, DATA_W bits per step, first bit in bit 0
module elec_prbs11_gen
    import elec_layer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] data
);

    logic [10:0] lfsr;
    logic [10:0] lfsr_next;
    logic [10:0] s;

    // load presents the seed's symbol in the same cycle so a set starts without a bubble
    always_comb begin
        s    = load ? PRBS11_SEED : lfsr;
        data = '0;
        for (int i = 0; i < DATA_W; i++) begin
            data[i] = s[10];
            s       = {s[9:0], s[10] ^ s[8]};
        end
        lfsr_next = s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= PRBS11_SEED;
        end else if (load || advance) begin
            lfsr <= lfsr_next;
        end
    end

endmodule

// File: rtl/elec_layer_os_tx.sv
// rtl/elec_layer_os_tx.sv - ordered-set / data transmitter driving LANES electrical lanes
module elec_layer_os_tx
    import elec_layer_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DATA_W    = 8,
    parameter int OS_REPEAT = 16,
    parameter int SLOS_LEN  = 2048
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              os_cmd,
    input  logic                    os_cmd_valid,
    output logic                    os_cmd_ready,
    input  logic [LANES-1:0]        lane_en,
    input  logic [LANES*DATA_W-1:0] data_in,
    input  logic                    data_in_valid,
    output logic                    data_in_ready,
    output logic [LANES*DATA_W-1:0] lane_out,
    output logic                    lane_out_valid,
    output logic                    os_done
);

    localparam int SLOS_SYMS = SLOS_LEN / DATA_W;
    localparam int TS_SYMS   = 32 / DATA_W;

    os_state_e state, next_state, mode, cmd_state;
    logic [15:0] sym_cnt, set_cnt, emit_idx, emit_set, sym_next, set_next, syms_m1;
    logic        inv_q, inv_d, ts2_q, ts2_d;
    logic        accept, emit, last, done_pend;
    logic        prbs_load, prbs_adv;
    logic [31:0] ts_pat;
    logic [DATA_W-1:0]       ts_sym;
    logic [LANES*DATA_W-1:0] prbs_bus, lane_d;
    logic                    valid_d;

    assign os_cmd_ready  = (state == ST_IDLE) || (state == ST_DATA);
    assign data_in_ready = (state == ST_DATA);
    assign accept        = os_cmd_valid && os_cmd_ready;

    always_comb begin
        case (os_cmd)
            CMD_SLOS1, CMD_SLOS2: cmd_state = ST_SLOS;
            CMD_TS1, CMD_TS2:     cmd_state = ST_TS;
            CMD_DATA:             cmd_state = ST_DATA;
            default:              cmd_state = ST_IDLE;
        endcase
    end

    // mode is what gets driven this cycle; a command accepted alongside a DATA word waits one cycle
    always_comb begin
        next_state = state;
        mode       = state;
        inv_d      = inv_q;
        ts2_d      = ts2_q;
        emit_idx   = sym_cnt;
        emit_set   = set_cnt;
        if (accept) begin
            next_state = cmd_state;
            inv_d      = (os_cmd == CMD_SLOS2);
            ts2_d      = (os_cmd == CMD_TS2);
            emit_idx   = '0;
            emit_set   = '0;
            if (!(state == ST_DATA && data_in_valid)) begin
                mode = cmd_state;
            end
        end
        emit    = (mode == ST_SLOS) || (mode == ST_TS);
        syms_m1 = (mode == ST_SLOS) ? 16'(SLOS_SYMS - 1) : 16'(TS_SYMS - 1);
        last    = emit && (emit_idx == syms_m1) && (emit_set == 16'(OS_REPEAT - 1));
        sym_next = '0;
        set_next = '0;
        if (emit && !last) begin
            if (emit_idx == syms_m1) begin
                set_next = emit_set + 16'd1;
            end else begin
                sym_next = emit_idx + 16'd1;
                set_next = emit_set;
            end
        end
        if (last) begin
            next_state = ST_IDLE;
        end
        prbs_load = (mode == ST_SLOS) && (emit_idx == '0);
        prbs_adv  = (mode == ST_SLOS);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        elec_prbs11_gen #(.DATA_W(DATA_W)) u_prbs (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (prbs_load),
            .advance (prbs_adv),
            .data    (prbs_bus[k*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        ts_pat  = ts2_d ? TS2_PATTERN : TS1_PATTERN;
        ts_sym  = DATA_W'(ts_pat >> (int'(emit_idx) * DATA_W));
        lane_d  = '0;
        valid_d = 1'b0;
        case (mode)
            ST_SLOS: begin
                lane_d  = inv_d ? ~prbs_bus : prbs_bus;
                valid_d = 1'b1;
            end
            ST_TS: begin
                lane_d  = {LANES{ts_sym}};
                valid_d = 1'b1;
            end
            ST_DATA: begin
                lane_d  = data_in;
                valid_d = data_in_valid;
            end
            default: ;
        endcase
        for (int k = 0; k < LANES; k++) begin
            if (!lane_en[k]) begin
                lane_d[k*DATA_W +: DATA_W] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt        <= '0;
            set_cnt        <= '0;
            inv_q          <= 1'b0;
            ts2_q          <= 1'b0;
            lane_out       <= '0;
            lane_out_valid <= 1'b0;
            done_pend      <= 1'b0;
            os_done        <= 1'b0;
        end else begin
            sym_cnt        <= sym_next;
            set_cnt        <= set_next;
            inv_q          <= inv_d;
            ts2_q          <= ts2_d;
            lane_out       <= lane_d;
            lane_out_valid <= valid_d;
            done_pend      <= last;
            os_done        <= done_pend;
        end
    end

endmodule

// File: tb/tb_elec_layer_os_tx.sv
// tb/tb_elec_layer_os_tx.sv - scoreboard bench for elec_layer_os_tx (LANES=2, DATA_W=8, OS_REPEAT=2)
module tb_elec_layer_os_tx;

    localparam int LANES     = 2;
    localparam int DATA_W    = 8;
    localparam int OS_REPEAT = 2;
    localparam int SLOS_LEN  = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  os_cmd = 3'd0;
    logic        os_cmd_valid = 1'b0;
    logic        os_cmd_ready;
    logic [1:0]  lane_en = 2'b11;
    logic [15:0] data_in = 16'h0;
    logic        data_in_valid = 1'b0;
    logic        data_in_ready;
    logic [15:0] lane_out;
    logic        lane_out_valid;
    logic        os_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];
    bit prbs[SLOS_LEN];

    elec_layer_os_tx #(
        .LANES(LANES), .DATA_W(DATA_W), .OS_REPEAT(OS_REPEAT), .SLOS_LEN(SLOS_LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .os_cmd(os_cmd), .os_cmd_valid(os_cmd_valid),
        .os_cmd_ready(os_cmd_ready), .lane_en(lane_en), .data_in(data_in),
        .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
        .lane_out(lane_out), .lane_out_valid(lane_out_valid), .os_done(os_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && os_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (lane_out_valid) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected no output", lane_out);
            end else begin
                check("lane_out", {16'h0, lane_out}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic push_slos(input bit inv, input logic [1:0] en);
        logic [7:0] b;
        for (int s = 0; s < OS_REPEAT; s++) begin
            for (int j = 0; j < SLOS_LEN / 8; j++) begin
                for (int t = 0; t < 8; t++) b[t] = prbs[8*j + t];
                if (inv) b = ~b;
                exp_q.push_back({en[1] ? b : 8'h00, en[0] ? b : 8'h00});
            end
        end
    endtask

    task automatic push_ts(input logic [31:0] pat, input logic [1:0] en);
        logic [7:0] b;
        for (int s = 0; s < OS_REPEAT; s++) begin
            for (int j = 0; j < 4; j++) begin
                b = pat[8*j +: 8];
                exp_q.push_back({en[1] ? b : 8'h00, en[0] ? b : 8'h00});
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [2:0] c, output int acc);
        int n = 0;
        while (!os_cmd_ready && n < 2000) begin
            tick(1);
            n++;
        end
        if (!os_cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_ready_timeout: got 0 expected 1");
        end
        os_cmd = c;
        os_cmd_valid = 1'b1;
        tick(1);
        os_cmd_valid = 1'b0;
        acc = cyc;
    endtask

    task automatic wait_done(input string name, input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick(1);
            n++;
        end
        if (done_cnt == start) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no os_done expected os_done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int a;
        int v0;
        int d0;
        int n;
        for (int i = 0; i < 11; i++) prbs[i] = 1'b1;
        for (int i = 11; i < SLOS_LEN; i++) prbs[i] = prbs[i-11] ^ prbs[i-9];

        tick(3);
        check("rst_lane_out", {16'h0, lane_out}, 32'h0);
        check("rst_valid", {31'h0, lane_out_valid}, 32'h0);
        check("rst_done", {31'h0, os_done}, 32'h0);
        check("rst_data_ready", {31'h0, data_in_ready}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_cmd_ready", {31'h0, os_cmd_ready}, 32'h1);

        // TS1: eight bytes, os_done in the ninth cycle after acceptance
        push_ts(32'h0F0F_00F2, 2'b11);
        issue(3'd3, a);
        wait_done("ts1", 50);
        check("ts1_done_cycle", done_cyc - a, 32'd8);
        tick(3);
        check("ts1_queue_empty", exp_q.size(), 32'd0);

        // SLOS1 then SLOS2
        v0 = valid_cnt;
        push_slos(1'b0, 2'b11);
        issue(3'd1, a);
        wait_done("slos1", 700);
        tick(2);
        check("slos1_valid_cycles", valid_cnt - v0, 32'd512);
        check("slos1_queue_empty", exp_q.size(), 32'd0);

        v0 = valid_cnt;
        push_slos(1'b1, 2'b11);
        issue(3'd2, a);
        wait_done("slos2", 700);
        tick(2);
        check("slos2_valid_cycles", valid_cnt - v0, 32'd512);
        check("slos2_queue_empty", exp_q.size(), 32'd0);

        // TS2 with lane 1 disabled
        lane_en = 2'b01;
        push_ts(32'h0F0F_00F4, 2'b01);
        issue(3'd4, a);
        wait_done("ts2", 50);
        check("ts2_done_cycle", done_cyc - a, 32'd8);
        tick(2);
        check("ts2_queue_empty", exp_q.size(), 32'd0);
        lane_en = 2'b11;

        // DATA pass-through
        issue(3'd5, a);
        check("data_ready", {31'h0, data_in_ready}, 32'h1);
        data_in = 16'hA55A;
        data_in_valid = 1'b1;
        repeat (3) exp_q.push_back(16'hA55A);
        tick(3);
        data_in_valid = 1'b0;
        tick(3);
        check("data_queue_empty", exp_q.size(), 32'd0);
        check("data_cmd_ready", {31'h0, os_cmd_ready}, 32'h1);

        // command accepted together with a data word: word first, TS1 one cycle later
        data_in = 16'h1234;
        data_in_valid = 1'b1;
        exp_q.push_back(16'h1234);
        push_ts(32'h0F0F_00F2, 2'b11);
        issue(3'd3, a);
        data_in_valid = 1'b0;
        wait_done("data_to_ts", 50);
        check("data_to_ts_done_cycle", done_cyc - a, 32'd9);
        tick(2);
        check("data_to_ts_queue_empty", exp_q.size(), 32'd0);

        // asynchronous reset in the middle of a SLOS set, then replay
        push_slos(1'b0, 2'b11);
        v0 = valid_cnt;
        issue(3'd1, a);
        n = 0;
        while (valid_cnt - v0 < 100 && n < 300) begin
            tick(1);
            n++;
        end
        check("mid_slos_reached", (valid_cnt - v0 >= 100) ? 32'd1 : 32'd0, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_lane_out", {16'h0, lane_out}, 32'h0);
        check("async_rst_valid", {31'h0, lane_out_valid}, 32'h0);
        check("async_rst_ready", {31'h0, data_in_ready}, 32'h0);
        exp_q.delete();
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("replay_cmd_ready", {31'h0, os_cmd_ready}, 32'h1);
        push_slos(1'b0, 2'b11);
        issue(3'd1, a);
        wait_done("slos_replay", 700);
        tick(2);
        check("replay_queue_empty", exp_q.size(), 32'd0);

        // TS2 offered during SLOS must be dropped
        push_slos(1'b0, 2'b11);
        d0 = done_cnt;
        issue(3'd1, a);
        tick(50);
        check("slos_cmd_ready_low", {31'h0, os_cmd_ready}, 32'h0);
        os_cmd = 3'd4;
        os_cmd_valid = 1'b1;
        tick(1);
        os_cmd_valid = 1'b0;
        wait_done("slos_ignore", 700);
        tick(20);
        check("ignored_done_count", done_cnt - d0, 32'd1);
        check("ignored_queue_empty", exp_q.size(), 32'd0);
        check("ignored_final_valid", {31'h0, lane_out_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
